// File: rtl/retire_if.sv
// Hart retire port: one retired instruction per valid cycle, produced by the
// hart (master) and consumed by the retire monitor (slave).
interface retire_if;
  logic        valid;
  logic [31:0] inst;
  logic        trap;
  logic        halt;
  logic [4:0]  rs1_raddr;
  logic [31:0] rs1_rdata;
  logic [4:0]  rs2_raddr;
  logic [31:0] rs2_rdata;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic [31:0] pc;
  logic [31:0] next_pc;

  modport master (
    output valid, inst, trap, halt, rs1_raddr, rs1_rdata, rs2_raddr,
           rs2_rdata, rd_waddr, rd_wdata, pc, next_pc
  );
  modport slave (
    input  valid, inst, trap, halt, rs1_raddr, rs1_rdata, rs2_raddr,
           rs2_rdata, rd_waddr, rd_wdata, pc, next_pc
  );
endinterface

// File: rtl/retire_monitor.sv
// Retire-stream checker: shadows the register file, checks PC continuity and
// operand values, counts cycles/retirements, and latches the first failure.
module retire_monitor #(
  parameter logic [31:0] RESET_ADDR = 32'h0,
  parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  retire_if.slave     i_retire,
  output logic [1:0]  o_state,
  output logic        o_done,
  output logic        o_error,
  output logic [2:0]  o_err_code,
  output logic [31:0] o_err_pc,
  output logic [31:0] o_retired_count,
  output logic [31:0] o_cycle_count,
  output logic [31:0] o_a0
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_PC    = 3'd1;
  localparam logic [2:0] ERR_RS1   = 3'd2;
  localparam logic [2:0] ERR_RS2   = 3'd3;
  localparam logic [2:0] ERR_TRAP  = 3'd4;
  localparam logic [2:0] ERR_WDOG  = 3'd5;
  localparam logic [2:0] ERR_ALIGN = 3'd6;

  state_t      r_state;
  logic [31:0] r_shadow [32];
  logic [31:0] r_expected_pc;
  logic [2:0]  r_err_code;
  logic [31:0] r_err_pc;
  logic [31:0] r_retired;
  logic [31:0] r_cycles;

  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [2:0]  w_fail_code;
  logic        w_active;
  logic        w_watchdog;
  logic        w_cycle_inc;
  logic        w_unused_inst;

  // The instruction word is carried for waveform debug only.
  assign w_unused_inst = ^i_retire.inst;

  assign w_rs1_val = (i_retire.rs1_raddr == 5'd0) ? 32'h0 : r_shadow[i_retire.rs1_raddr];
  assign w_rs2_val = (i_retire.rs2_raddr == 5'd0) ? 32'h0 : r_shadow[i_retire.rs2_raddr];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the priority chain can leave it unassigned and infer a latch.
  always_comb begin
    w_fail_code = ERR_NONE;
    if (i_retire.pc != r_expected_pc)            w_fail_code = ERR_PC;
    else if (i_retire.rs1_rdata != w_rs1_val)    w_fail_code = ERR_RS1;
    else if (i_retire.rs2_rdata != w_rs2_val)    w_fail_code = ERR_RS2;
    else if (i_retire.trap)                      w_fail_code = ERR_TRAP;
    else if (i_retire.next_pc[1:0] != 2'b00)     w_fail_code = ERR_ALIGN;
  end

  assign w_active    = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign w_watchdog  = (r_state == ST_RUN) && (r_cycles == MAX_CYCLES);
  // The edge that moves IDLE->RUN already counts as the first RUN cycle.
  assign w_cycle_inc = (r_state == ST_RUN) ||
                       (i_retire.valid && (w_fail_code == ERR_NONE) && !i_retire.halt);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which the "old shadow value" rule depends on.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_expected_pc <= RESET_ADDR;
      r_err_code    <= ERR_NONE;
      r_err_pc      <= 32'h0;
      r_retired     <= 32'h0;
      r_cycles      <= 32'h0;
      // NOTE: the shadow file must reset; a mid-run reset restarts the
      // program and operand checks would otherwise see stale values.
      for (int i = 0; i < 32; i++) r_shadow[i] <= 32'h0;
    end else if (w_watchdog) begin
      r_state    <= ST_ERROR;
      r_err_code <= ERR_WDOG;
      r_err_pc   <= r_expected_pc;
    end else if (w_active) begin
      if (w_cycle_inc && (r_cycles != 32'hFFFF_FFFF)) r_cycles <= r_cycles + 32'd1;
      if (i_retire.valid) begin
        if (w_fail_code != ERR_NONE) begin
          r_state    <= ST_ERROR;
          r_err_code <= w_fail_code;
          r_err_pc   <= i_retire.pc;
        end else begin
          if (i_retire.rd_waddr != 5'd0) r_shadow[i_retire.rd_waddr] <= i_retire.rd_wdata;
          r_expected_pc <= i_retire.next_pc;
          if (r_retired != 32'hFFFF_FFFF) r_retired <= r_retired + 32'd1;
          r_state <= i_retire.halt ? ST_HALTED : ST_RUN;
        end
      end
    end
  end

  assign o_state         = r_state;
  assign o_done          = (r_state == ST_HALTED) || (r_state == ST_ERROR);
  assign o_error         = (r_state == ST_ERROR);
  assign o_err_code      = r_err_code;
  assign o_err_pc        = r_err_pc;
  assign o_retired_count = r_retired;
  assign o_cycle_count   = r_cycles;
  assign o_a0            = r_shadow[10];

endmodule
